// File: rtl/conv_window_sequencer.sv
// 3x3 window fetch / conv / write-back sequencer over a 130x130 padded image.
// Define SLIDE_REUSE_EN to refetch only the new column when sliding right.
module conv_window_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_en,
  output logic [14:0] rd_addr,
  output logic        win_load,
  output logic [3:0]  win_idx,
  output logic        shift_right,
  output logic        start_conv,
  input  logic        done_conv,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, CONV, WAIT, WRITE, NEXT, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  r_q, r_d;
  logic [6:0]  c_q, c_d;
  logic [1:0]  i_q, i_d;
  logic [1:0]  j_q, j_d;
  logic        part_q, part_d;
  logic        ld_q, ld_d;
  logic [3:0]  ld_idx_q, ld_idx_d;

  logic        reuse_ok;
  logic [3:0]  slot;
  logic [14:0] row_w;
  logic [14:0] col_w;
  logic [14:0] rd_calc;

`ifdef SLIDE_REUSE_EN
  // Sliding within a row keeps columns 1,2 of the old window.
  assign reuse_ok = (c_q != 7'd127);
`else
  assign reuse_ok = 1'b0;
`endif

  assign slot    = ({2'b00, i_q} * 4'd3) + {2'b00, j_q};
  assign row_w   = {8'd0, r_q} + {13'd0, i_q};
  assign col_w   = {8'd0, c_q} + {13'd0, j_q};
  assign rd_calc = (row_w * 15'd130) + col_w;

  assign win_load = ld_q;
  assign win_idx  = ld_q ? ld_idx_q : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= 7'd0;
      c_q      <= 7'd0;
      i_q      <= 2'd0;
      j_q      <= 2'd0;
      part_q   <= 1'b0;
      ld_q     <= 1'b0;
      ld_idx_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      part_q   <= part_d;
      ld_q     <= ld_d;
      ld_idx_q <= ld_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    i_d         = i_q;
    j_d         = j_q;
    part_d      = part_q;
    ld_d        = 1'b0;
    ld_idx_d    = 4'd0;
    rd_en       = 1'b0;
    rd_addr     = 15'd0;
    shift_right = 1'b0;
    start_conv  = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 14'd0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          r_d     = 7'd0;
          c_d     = 7'd0;
          i_d     = 2'd0;
          j_d     = 2'd0;
          part_d  = 1'b0;
        end
      end
      FETCH: begin
        rd_en    = 1'b1;
        rd_addr  = rd_calc;
        ld_d     = 1'b1;
        ld_idx_d = slot;
        if (i_q == 2'd2 && j_q == 2'd2) begin
          state_d = DRAIN;
        end else if (part_q || j_q == 2'd2) begin
          i_d = i_q + 2'd1;
          j_d = part_q ? 2'd2 : 2'd0;
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      DRAIN: state_d = CONV;
      CONV: begin
        start_conv = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (done_conv) state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {r_q, c_q};
        state_d = NEXT;
      end
      NEXT: begin
        shift_right = reuse_ok;
        part_d      = reuse_ok;
        i_d         = 2'd0;
        j_d         = reuse_ok ? 2'd2 : 2'd0;
        if (c_q == 7'd127) begin
          c_d = 7'd0;
          if (r_q == 7'd127) begin
            state_d = FIN;
          end else begin
            r_d     = r_q + 7'd1;
            state_d = FETCH;
          end
        end else begin
          c_d     = c_q + 7'd1;
          state_d = FETCH;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: timeline model, random done_conv latency.
// Build with -DSLIDE_REUSE_EN to check the window-reuse variant.
module tb_conv_window_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done_conv = 1'b0;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic        win_load;
  logic [3:0]  win_idx;
  logic        shift_right;
  logic        start_conv;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic        done;

  always #5 clk = ~clk;

  conv_window_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .win_load(win_load), .win_idx(win_idx),
    .shift_right(shift_right), .start_conv(start_conv),
    .done_conv(done_conv), .wr_en(wr_en),
    .wr_addr(wr_addr), .done(done)
  );

`ifdef SLIDE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int dmode = 1;

  // Model: phase 0 idle, 1 pixel timeline, 2 write, 3 advance, 4 finish
  int mph = 0;
  int mr = 0;
  int mc = 0;
  int mt = 0;
  bit mre = 1'b0;

  int rd_log[$];
  int wr_log[$];
  int done_cnt = 0;
  int first_rd = -1;
  bit arm_first = 1'b0;

  function automatic int nrd(bit re);
    return re ? 3 : 9;
  endfunction

  function automatic int slot_of(bit re, int k);
    return re ? 3 * k + 2 : k;
  endfunction

  function automatic int addr_of(int r, int c, int s);
    return (r + s / 3) * 130 + c + s % 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int e_rd, e_ra, e_wl, e_wi, e_sr, e_sc, e_we, e_wa, e_dn, n;
    e_rd = 0; e_ra = 0; e_wl = 0; e_wi = 0; e_sr = 0;
    e_sc = 0; e_we = 0; e_wa = 0; e_dn = 0;
    n = nrd(mre);
    if (!rst) begin
      case (mph)
        1: begin
          if (mt < n) begin
            e_rd = 1;
            e_ra = addr_of(mr, mc, slot_of(mre, mt));
          end
          if (mt >= 1 && mt <= n) begin
            e_wl = 1;
            e_wi = slot_of(mre, mt - 1);
          end
          if (mt == n + 1) e_sc = 1;
        end
        2: begin
          e_we = 1;
          e_wa = mr * 128 + mc;
        end
        3: e_sr = (REUSE && mc != 127) ? 1 : 0;
        4: e_dn = 1;
        default: ;
      endcase
    end
    chk("rd_en", rd_en, e_rd);
    chk("rd_addr", rd_addr, e_ra);
    chk("win_load", win_load, e_wl);
    chk("win_idx", win_idx, e_wi);
    chk("shift_right", shift_right, e_sr);
    chk("start_conv", start_conv, e_sc);
    chk("wr_en", wr_en, e_we);
    chk("wr_addr", wr_addr, e_wa);
    chk("done", done, e_dn);
    if (rd_en && rd_log.size() < 2000) rd_log.push_back(rd_addr);
    if (rd_en && arm_first) begin
      first_rd = rd_addr;
      arm_first = 1'b0;
    end
    if (wr_en) wr_log.push_back(wr_addr);
    if (done) done_cnt++;
    if (rst) begin
      mph = 0;
    end else begin
      case (mph)
        0: if (start) begin
          mph = 1; mr = 0; mc = 0; mt = 0; mre = 1'b0;
        end
        1: begin
          if (mt <= n + 1) mt++;
          else if (done_conv) mph = 2;
        end
        2: mph = 3;
        3: begin
          if (mr == 127 && mc == 127) begin
            mph = 4;
          end else begin
            mre = REUSE && (mc != 127);
            if (mc == 127) begin
              mc = 0;
              mr++;
            end else begin
              mc++;
            end
            mt = 0;
            mph = 1;
          end
        end
        4: mph = 0;
        default: mph = 0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (dmode)
      0: done_conv = ($urandom_range(0, 3) == 0);
      1: done_conv = 1'b0;
      default: done_conv = 1'b1;
    endcase
  end

  task automatic wait_model(input bit in_wait, output bit ok);
    ok = 1'b0;
    for (int b = 0; b < 600 && !ok; b++) begin
      @(posedge clk);
      #2;
      if (mph == 1 && (in_wait ? (mt >= nrd(mre) + 2) : (mt == 4)))
        ok = 1'b1;
    end
  endtask

  task automatic reset_mid(input bit in_wait, input string tag);
    bit ok;
    wait_model(in_wait, ok);
    chk({tag, "_reach"}, ok, 1);
    rst = 1'b1;
    #1;
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_win_load"}, win_load, 0);
    chk({tag, "_win_idx"}, win_idx, 0);
    chk({tag, "_shift"}, shift_right, 0);
    chk({tag, "_sconv"}, start_conv, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_done"}, done, 0);
    first_rd = -1;
    arm_first = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int b = 0; b < 100 && first_rd < 0; b++) @(posedge clk);
    chk({tag, "_restart_addr"}, first_rd, 0);
  endtask

  initial begin
    int bud;
    int bad;
    int idx;
    int exp0[9];
    exp0 = '{0, 1, 2, 130, 131, 132, 260, 261, 262};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_win_load", win_load, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_read", rd_en, 0);
    start = 1'b1;
    dmode = 2;
    @(posedge clk);
    #1 start = 1'b0;

    bud = 0;
    while (wr_log.size() < 130 && bud < 20000) begin
      @(posedge clk);
      bud++;
      if (wr_log.size() >= 40) dmode = 0;
    end
    chk("pass_progress", (bud < 20000) ? 1 : 0, 1);

    for (int k = 0; k < 9; k++) chk("pix00_rd", rd_log[k], exp0[k]);
`ifdef SLIDE_REUSE_EN
    chk("pix01_rd0", rd_log[9], 3);
    chk("pix01_rd1", rd_log[10], 133);
    chk("pix01_rd2", rd_log[11], 263);
    idx = 9 + 127 * 3;
`else
    chk("pix01_rd0", rd_log[9], 1);
    chk("pix01_rd8", rd_log[17], 263);
    idx = 128 * 9;
`endif
    chk("pix10_rd0", rd_log[idx], 130);
    chk("pix10_rd1", rd_log[idx + 1], 131);
    chk("wr_127", wr_log[127], 127);
    chk("wr_128", wr_log[128], 128);
    bad = 0;
    for (int k = 0; k < 130; k++) if (wr_log[k] != k) bad++;
    chk("wr_sequence", bad, 0);

    dmode = 1;
    begin
      bit ok;
      wait_model(1'b1, ok);
      chk("final_reach_wait", ok, 1);
    end
    force dut.r_q = 7'd127;
    force dut.c_q = 7'd127;
    mr = 127;
    mc = 127;
    start = 1'b1;
    dmode = 0;
    bud = 0;
    while (done_cnt == 0 && bud < 400) begin
      @(posedge clk);
      #2;
      bud++;
    end
    release dut.r_q;
    release dut.c_q;
    chk("final_done_seen", done_cnt, 1);
    chk("final_wr_addr", wr_log[wr_log.size() - 1], 16383);
    first_rd = -1;
    arm_first = 1'b1;
    for (int b = 0; b < 100 && first_rd < 0; b++) @(posedge clk);
    chk("restart_after_fin", first_rd, 0);

    reset_mid(1'b0, "rst_fetch");
    reset_mid(1'b1, "rst_wait");
    repeat (200) @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  level; begins a full-image pass when sampled high in IDLE.
REQ-004 SHALL have port rd_en  output  1  read strobe to the 130x130 padded input BRAM.
REQ-005 SHALL have port rd_addr  output  15  input BRAM address, 0..16899.
REQ-006 SHALL have port win_load  output  1  write strobe into the 3x3 window register; BRAM data is valid this cycle.
REQ-007 SHALL have port win_idx  output  4  window slot for win_load, 0..8, row-major (slot = 3*i+j).
REQ-008 SHALL have port shift_right  output  1  one-cycle pulse shifting the window one column left.
REQ-009 SHALL have port start_conv  output  1  one-cycle start pulse to the 2-D conv circuit.
REQ-010 SHALL have port done_conv  input  1  conv circuit result ready, level.
REQ-011 SHALL have port wr_en  output  1  result write strobe to the 128x128 output BRAM.
REQ-012 SHALL have port wr_addr  output  14  output address r*128+c, 0..16383.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the whole image is processed.

Function
REQ-014 SHALL implement states IDLE, FETCH, DRAIN, CONV, WAIT, WRITE, NEXT, FIN.
REQ-015 SHALL keep output row r and column c counters (7 bits each), both 0 on leaving IDLE.
REQ-016 In FETCH SHALL assert rd_en once per cycle with rd_addr = (r+i)*130 + (c+j) over the slots to fetch, in ascending slot order.
REQ-017 SHALL assert win_load with the matching win_idx exactly one cycle after each rd_en (1-cycle BRAM latency); DRAIN covers the final slot.
REQ-018 Full fetch SHALL read all 9 slots: 9 FETCH cycles + 1 DRAIN cycle.
REQ-019 CONV SHALL last one cycle with start_conv high, then move to WAIT.
REQ-020 WAIT SHALL hold until done_conv is sampled high, then go to WRITE.
REQ-021 WRITE SHALL last one cycle with wr_en high and wr_addr = r*128+c.
REQ-022 NEXT SHALL advance c; at c=127 wrap c to 0 and increment r; after (127,127) go to FIN, otherwise to FETCH.
REQ-023 FIN SHALL pulse done for one cycle, then enter IDLE; if start is still high, a new pass begins.
REQ-024 SHALL ignore start outside IDLE and ignore done_conv outside WAIT.
REQ-025 rd_addr, wr_addr, win_idx SHALL be 0 whenever their strobe is low.
REQ-026 Address arithmetic SHALL be at least 15 bits wide and SHALL NOT overflow (maximum 16899).

Reset
REQ-027 rst high SHALL force IDLE, clear r and c, and drive every output to 0 immediately, including mid-pass.
REQ-028 After rst is released the block SHALL idle until start is sampled high.

Configuration
REQ-029 Macro SLIDE_REUSE_EN SHALL select the window-reuse feature.
REQ-030 With SLIDE_REUSE_EN defined and c>0: NEXT SHALL pulse shift_right, then FETCH SHALL read only slots 2,5,8 (column c+2): 3 FETCH cycles + 1 DRAIN cycle.
REQ-031 With SLIDE_REUSE_EN defined and c=0: SHALL use a full 9-slot fetch with no shift_right pulse.
REQ-032 Without SLIDE_REUSE_EN: every pixel SHALL use a full fetch, and shift_right SHALL stay 0.

Verification
REQ-033 Start pass -> pixel (0,0): rd_addr 0,1,2,130,131,132,260,261,262; win_idx 0..8 each one cycle later; one start_conv pulse.
REQ-034 SLIDE_REUSE_EN, pixel (0,1) -> one shift_right pulse, then rd_addr 3,133,263 with win_idx 2,5,8; without the macro -> 9 reads starting at address 1.
REQ-035 Row wrap, pixel (0,127) done -> wr_addr 127, then full fetch for (1,0) starting at rd_addr 130 with no shift_right.
REQ-036 done_conv held high 26 cycles after start_conv, then pulsed -> exactly one wr_en per pixel; the early level is ignored outside WAIT.
REQ-037 Final pixel -> wr_addr 16383, then done high one cycle; total wr_en count 16384.
REQ-038 rst asserted during WAIT -> all outputs 0 the same cycle; after release with start high, the pass restarts at rd_addr 0.
